// File: rtl/ddr_fsw_seq.sv
// Frequency-switch sequencer: gates clocks, performs a four-phase VCO select
// handshake with the PLL, updates the MSR select and reports busy/done/error.
module ddr_fsw_seq #(
    parameter int CW      = 8,
    parameter int TW      = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_hclk,
    input  logic          i_hreset,
    input  logic          i_sw_req,
    input  logic [1:0]    i_tgt_vco,
    input  logic          i_tgt_msr,
    input  logic [CW-1:0] i_prep_cnt,
    input  logic [CW-1:0] i_post_cnt,
    output logic          o_clk_gate,
    output logic [1:0]    o_vco_sel,
    output logic          o_vco_req,
    input  logic          i_vco_ack,
    output logic          o_msr,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [2:0]    o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_REQ  = 3'd2,
        S_REL  = 3'd3,
        S_MSR  = 3'd4,
        S_POST = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt_nxt;
    logic          w_accept;
    logic          r_tgt_msr;
    logic [CW-1:0] r_post_cnt;
    logic          r_clk_gate;
    logic [1:0]    r_vco_sel;
    logic          r_vco_req;
    logic          r_msr;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    // Next-state and counter logic; counters stop at 1 (settle) or at the timeout limit.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_tcnt_nxt   = r_tcnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_sw_req) begin
                    w_accept     = 1'b1;
                    w_next_state = S_PREP;
                    w_cnt_nxt    = (i_prep_cnt == '0) ? CNT_ONE : i_prep_cnt;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_PREP: begin
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = S_REQ;
                    w_tcnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_REQ: begin
                if (i_vco_ack) begin
                    w_next_state = S_REL;
                    w_tcnt_nxt   = '0;
                end else if (r_tcnt >= TO_LAST) begin
                    w_next_state = S_ERR;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            S_REL: begin
                if (!i_vco_ack) begin
                    w_next_state = S_MSR;
                end else if (r_tcnt >= TO_LAST) begin
                    w_next_state = S_ERR;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            S_MSR: begin
                w_next_state = S_POST;
                w_cnt_nxt    = (r_post_cnt == '0) ? CNT_ONE : r_post_cnt;
            end
            S_POST: begin
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_ERR: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, latched targets and registered outputs derived from the next state.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_tgt_msr  <= 1'b0;
            r_post_cnt <= '0;
            r_clk_gate <= 1'b0;
            r_vco_sel  <= 2'd0;
            r_vco_req  <= 1'b0;
            r_msr      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_busy     <= (w_next_state != S_IDLE);
            r_clk_gate <= (w_next_state != S_IDLE);
            r_vco_req  <= (w_next_state == S_REQ);
            if (w_accept) begin
                r_tgt_msr  <= i_tgt_msr;
                r_post_cnt <= i_post_cnt;
                r_vco_sel  <= i_tgt_vco;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end
            if (r_state == S_REL && w_next_state == S_MSR) begin
                r_msr <= r_tgt_msr;
            end
            if (r_state == S_POST && w_next_state == S_IDLE) begin
                r_done <= 1'b1;
            end
            if (w_next_state == S_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_clk_gate = r_clk_gate;
    assign o_vco_sel  = r_vco_sel;
    assign o_vco_req  = r_vco_req;
    assign o_msr      = r_msr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_state    = r_state;

endmodule

// File: tb/tb_ddr_fsw_seq.sv
// Scoreboard bench for ddr_fsw_seq: a sequence-level model predicts the per-cycle
// state trace and final status; a monitor compares whatever the DUT presents.
module tb_ddr_fsw_seq;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_req;
    logic [1:0] tgt_vco;
    logic       tgt_msr;
    logic [7:0] prep_cnt;
    logic [7:0] post_cnt;
    logic       clk_gate;
    logic [1:0] vco_sel;
    logic       vco_req;
    logic       ack = 1'b0;
    logic       msr;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state;

    typedef struct {
        logic [2:0] st;
        logic [1:0] vs;
        logic       ms;
        logic       rq;
    } step_t;

    typedef struct {
        logic       dn;
        logic       er;
        logic [1:0] vs;
        logic       ms;
    } res_t;

    step_t q_tr[$];
    res_t  q_res[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   hi_dly = 0;
    int   lo_dly = 0;
    int   hi_c   = 0;
    int   lo_c   = 0;
    logic m_msr  = 1'b0;
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;

    ddr_fsw_seq #(.CW(8), .TW(10), .TIMEOUT(TO)) dut (
        .i_hclk     (clk),
        .i_hreset   (rst),
        .i_sw_req   (sw_req),
        .i_tgt_vco  (tgt_vco),
        .i_tgt_msr  (tgt_msr),
        .i_prep_cnt (prep_cnt),
        .i_post_cnt (post_cnt),
        .o_clk_gate (clk_gate),
        .o_vco_sel  (vco_sel),
        .o_vco_req  (vco_req),
        .i_vco_ack  (ack),
        .o_msr      (msr),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PLL responder: ack rises hi_dly cycles after req is seen, falls lo_dly cycles after req drops.
    always @(negedge clk) begin
        if (rst) begin
            ack  <= 1'b0;
            hi_c <= 0;
            lo_c <= 0;
        end else if (vco_req) begin
            lo_c <= 0;
            hi_c <= hi_c + 1;
            if (hi_c + 1 > hi_dly) ack <= 1'b1;
        end else begin
            hi_c <= 0;
            if (ack) begin
                lo_c <= lo_c + 1;
                if (lo_c + 1 > lo_dly) ack <= 1'b0;
            end
        end
    end

    // Reference model: expected per-cycle trace and end status of one accepted sequence.
    task automatic model_seq(input logic [1:0] v, input logic m, input int p, input int q,
                             input int h, input int l);
        int pe = (p == 0) ? 1 : p;
        int qe = (q == 0) ? 1 : q;
        for (int i = 0; i < pe; i++) q_tr.push_back('{3'd1, v, m_msr, 1'b0});
        if (h <= TO - 1) begin
            for (int i = 0; i <= h; i++) q_tr.push_back('{3'd2, v, m_msr, 1'b1});
            for (int i = 0; i <= l; i++) q_tr.push_back('{3'd3, v, m_msr, 1'b0});
            q_tr.push_back('{3'd4, v, m, 1'b0});
            for (int i = 0; i < qe; i++) q_tr.push_back('{3'd5, v, m, 1'b0});
            m_msr = m;
            q_res.push_back('{1'b1, 1'b0, v, m});
        end else begin
            for (int i = 0; i < TO; i++) q_tr.push_back('{3'd2, v, m_msr, 1'b1});
            q_tr.push_back('{3'd6, v, m_msr, 1'b0});
            q_res.push_back('{1'b0, 1'b1, v, m_msr});
        end
    endtask

    // Monitor: every busy cycle pops a trace step; each return to IDLE pops an end status.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (q_tr.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    step_t e;
                    e = q_tr.pop_front();
                    chk("state", 32'(state), 32'(e.st));
                    chk("vco_sel", 32'(vco_sel), 32'(e.vs));
                    chk("msr", 32'(msr), 32'(e.ms));
                    chk("vco_req", 32'(vco_req), 32'(e.rq));
                    chk("clk_gate_busy", 32'(clk_gate), 32'd1);
                end
            end else if (prev_busy) begin
                if (q_res.size() == 0) begin
                    chk("unexpected_end", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = q_res.pop_front();
                    chk("end_done", 32'(done), 32'(r.dn));
                    chk("end_err", 32'(err), 32'(r.er));
                    chk("end_vco_sel", 32'(vco_sel), 32'(r.vs));
                    chk("end_msr", 32'(msr), 32'(r.ms));
                    chk("end_clk_gate", 32'(clk_gate), 32'd0);
                    chk("end_vco_req", 32'(vco_req), 32'd0);
                    chk("end_state", 32'(state), 32'd0);
                end
            end
            prev_busy <= busy;
        end else begin
            prev_busy <= 1'b0;
        end
    end

    // mode 0: single pulse; 1: request held through the whole sequence; 2: extra pulse in REQ.
    task automatic run_seq(input logic [1:0] v, input logic m, input int p, input int q,
                           input int h, input int l, input int mode);
        bit pulsed = 1'b0;
        bit ended  = 1'b0;
        @(negedge clk);
        hi_dly   = h;
        lo_dly   = l;
        tgt_vco  = v;
        tgt_msr  = m;
        prep_cnt = 8'(p);
        post_cnt = 8'(q);
        sw_req   = 1'b1;
        model_seq(v, m, p, q, h, l);
        @(negedge clk);
        tgt_vco  = ~v;
        tgt_msr  = ~m;
        prep_cnt = 8'($urandom_range(0, 9));
        post_cnt = 8'($urandom_range(0, 9));
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            if (mode == 2 && state == 3'd2 && !pulsed) begin
                sw_req  = 1'b1;
                tgt_vco = 2'd3;
                pulsed  = 1'b1;
            end else if (mode != 1) begin
                sw_req = 1'b0;
            end
            @(negedge clk);
        end
        sw_req = 1'b0;
        chk("seq_finished", 32'(ended), 32'd1);
        chk("trace_drained", 32'(q_tr.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        sw_req   = 1'b1;
        tgt_vco  = 2'd3;
        tgt_msr  = 1'b1;
        prep_cnt = 8'd2;
        post_cnt = 8'd2;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gate", 32'(clk_gate), 32'd0);
        chk("rst_vco_sel", 32'(vco_sel), 32'd0);
        chk("rst_vco_req", 32'(vco_req), 32'd0);
        chk("rst_msr", 32'(msr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        sw_req = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 32'(state), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

        run_seq(2'd2, 1'b1, 4, 3, 2, 0, 0);     // nominal
        run_seq(2'd1, 1'b0, 0, 0, 1, 0, 0);     // zero counts, ack after one cycle
        run_seq(2'd3, 1'b1, 1, 1, 1000, 0, 0);  // timeout, ack never comes
        run_seq(2'd1, 1'b1, 2, 1, 0, 1, 0);     // clears error
        run_seq(2'd1, 1'b0, 2, 2, 3, 1, 2);     // request while busy
        run_seq(2'd2, 1'b1, 0, 1, TO - 2, 0, 1);// held request incl. completion cycle

        // Reset while in REL, then a fresh sequence.
        mon_en = 1'b0;
        @(negedge clk);
        hi_dly = 0;
        lo_dly = 6;
        tgt_vco = 2'd1;
        tgt_msr = 1'b1;
        prep_cnt = 8'd1;
        post_cnt = 8'd1;
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (state == 3'd3) break;
            @(negedge clk);
        end
        chk("reached_rel", 32'(state), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_req", 32'(vco_req), 32'd0);
        chk("mid_rst_gate", 32'(clk_gate), 32'd0);
        chk("mid_rst_sel", 32'(vco_sel), 32'd0);
        chk("mid_rst_msr", 32'(msr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q_tr.delete();
        q_res.delete();
        m_msr  = 1'b0;
        mon_en = 1'b1;
        run_seq(2'd3, 1'b1, 3, 2, 1, 2, 0);

        for (int k = 0; k < 15; k++) begin
            int h;
            if ($urandom_range(0, 5) == 0) h = TO + $urandom_range(0, 4);
            else h = $urandom_range(0, 6);
            run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), $urandom_range(0, 6), h,
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("final_res_drained", 32'(q_res.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
